// File: rtl/int_to_half_serial.sv
// int_to_half_serial
//   Converts a signed 16-bit two's-complement fixed-point value
//   (Q(16-FRAC_BITS).FRAC_BITS) into an IEEE-754 half-precision word.
//   Normalisation shifts one bit per clock, so a conversion takes
//   between 1 and 17 cycles from acceptance to result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   converter can accept a word (high only when idle)
//   in_data    signed fixed-point input
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   FP16 result {sign, exp[4:0], mant[9:0]}
//
// Handshake: a word moves across an interface on a rising edge where
// valid and ready are both high. The source holds in_data/in_valid
// until in_ready; out_data/out_valid hold steady until out_ready.
// Only one word is in flight, so in_valid is ignored outside IDLE.

module int_to_half_serial #(
    parameter int FRAC_BITS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    generate
        if (FRAC_BITS < 0 || FRAC_BITS > 14) begin : g_bad_frac
            $error("int_to_half_serial: FRAC_BITS must be in 0..14");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] FRAC5 = 5'(FRAC_BITS);

    state_t      state;
    logic        sign;
    logic [15:0] mag;
    logic [4:0]  lz;

    // Rounding datapath, only meaningful in ROUND where mag[15] == 1.
    // The exponent always lands in 1..30, so 5 bits are enough.
    logic [4:0]  exp_base;
    logic [4:0]  exp_final;
    logic        guard_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [10:0] mant_sum;

    always_comb begin
        exp_base   = 5'd30 - lz - FRAC5;
        guard_bit  = mag[4];
        sticky_bit = |mag[3:0];
        round_up   = guard_bit & (sticky_bit | mag[5]);
        mant_sum   = {1'b0, mag[14:5]} + {10'd0, round_up};
        // A mantissa carry-out renormalises into the exponent.
        exp_final  = mant_sum[10] ? (exp_base + 5'd1) : exp_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            sign      <= 1'b0;
            mag       <= 16'h0000;
            lz        <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign     <= in_data[15];
                        // -32768 negates to itself, which is the correct
                        // unsigned magnitude 16'h8000.
                        mag      <= in_data[15] ? (16'd0 - in_data) : in_data;
                        lz       <= 5'd0;
                        if (in_data == 16'h0000) begin
                            // Zero skips normalisation; positive zero only.
                            out_data <= 16'h0000;
                            state    <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[15]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        lz  <= lz + 5'd1;
                    end
                end
                ROUND: begin
                    out_data  <= {sign, exp_final, mant_sum[9:0]};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // The zero path enters DONE with out_valid still low;
                    // raising it here gives the one-cycle zero latency.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
